muldiv_issue_arb: RTL and testbench
===================================

Name: muldiv_issue_arb

Overview:
- Arbitrates NREQ issue-queue requesters onto the single shared mul/div execution unit.
- Sequences the unit: one 1-cycle-result multiply or one iterative divide in flight at a time.
- Tracks divider occupancy with a countdown and drains a divide that is in flight when a flush arrives.
- Sits between the mul issue queues and the mul execute unit in the backend.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DW, `MUL_EXEPARAM_DW, width of one execute-parameter word; the 13 MSBs are the one-hot op field, ordered mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw, remuw.
- DIV_LAT, 66, maximum cycles from divide issue to writeback; also the watchdog bound.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- req_vaild  in  NREQ  requester i has an op.
- req_param  in  NREQ*DW  param word of requester i, at [DW*i +: DW].
- req_ready  out  NREQ  one-hot grant; combinational; the op is consumed when req_vaild[i] & req_ready[i].
- exe_vaild  out  1  registered issue pulse to the unit.
- exe_param  out  DW  registered param of the issued op.
- exe_ready  in  1  unit ready.
- wb_vaild  in  1  unit writeback.
- flush  in  1  pipeline flush.
- wb_kill  out  1  writeback belongs to a flushed op; the writeback stage discards it.
- busy  out  1  state != IDLE.
- wdog_err  out  1  one-cycle pulse when a divide exceeds DIV_LAT.

Behaviour:
- Reset values: exe_vaild=0, exe_param=0, wb_kill=0, wdog_err=0, state=IDLE, rr_ptr=0, cnt=0.
- States: IDLE, MUL, DIV, DRAIN.
- Issue condition: state==IDLE & exe_ready & ~flush & |req_vaild.
  - Round robin: the first vaild requester searching from rr_ptr upward, with wrap.
  - req_ready is nonzero only when the issue condition holds.
  - rr_ptr becomes grant+1 modulo NREQ after a grant.
- On issue:
  - Next cycle: exe_vaild=1 for exactly one cycle and exe_param holds the granted word.
  - Multiply class (mul, mulh, mulhsu, mulhu, mulw) -> state MUL.
  - Divide class -> state DIV, cnt=DIV_LAT.
- Illegal op fields: a zero op field, or one with more than one bit set, is not granted and is left in the requester.
- MUL: wb_vaild -> IDLE. Back-to-back: the next grant can occur in the cycle after wb_vaild.
- DIV:
  - cnt decrements each cycle while nonzero.
  - wb_vaild -> IDLE.
  - cnt reaching 0 without wb_vaild -> wdog_err pulse, then IDLE.
- Flush:
  - In IDLE or MUL: -> IDLE. A writeback arriving in the same cycle is passed with wb_kill=1.
  - In DIV: -> DRAIN; cnt keeps counting.
  - DRAIN: wb_kill=wb_vaild; exits to IDLE on wb_vaild or cnt==0, with no wdog_err in DRAIN.
  - A flush during DRAIN has no further effect.
- No grant in the flush cycle.
- exe_vaild is not suppressed by a flush arriving one cycle after issue; the unit itself drops it.
- Simultaneous wb_vaild and a new request: the request is granted no earlier than the next cycle.
- Asserting RST mid-operation returns to IDLE at once. The unit is reset by the same RST, so no drain is needed.

Optional Feature:
- Macro MULDIV_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round robin as above.

Decomposition:
- Shared package/header: op-field bit positions, is_mul/is_div class masks, state encodings, DIV_LAT default.
- One natural sub-module: muldiv_rr_pick, a parameterised round-robin picker (vaild vector + pointer -> one-hot grant).

Test Plan:
- Single mul from req0 at cycle 0, exe_ready=1 -> req_ready=01 at cycle 0, exe_vaild at cycle 1, busy until wb_vaild at cycle 2, IDLE at cycle 3.
- req0 and req1 both vaild continuously with mul ops -> grants alternate 01, 10, 01. With MULDIV_ARB_FIXED_PRIO_EN, req0 is always granted.
- div issued, wb_vaild returned 64 cycles later -> no grants for 64 cycles, IDLE after the writeback, wdog_err=0.
- div issued, flush at cycle 10, wb_vaild at cycle 64 -> state DRAIN, wb_kill=1 with that wb_vaild, no grant before cycle 65.
- div issued, no wb_vaild for 66 cycles -> wdog_err pulses once, IDLE, next request granted.
- RST asserted in DIV at cycle 20 -> outputs at reset values immediately, and the first grant follows RST deassertion.

Source files
------------

// File: rtl/muldiv_issue_arb_pkg.sv
// ============================================================================
// muldiv_issue_arb_pkg
// Shared op-field layout, mul/div class masks, arbiter state encodings and
// default divider latency for the mul/div issue arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef MUL_EXEPARAM_DW
`define MUL_EXEPARAM_DW 32
`endif

package muldiv_issue_arb_pkg;

    localparam int MUL_EXEPARAM_DW = `MUL_EXEPARAM_DW;
    localparam int DIV_LAT_DEF     = 66;

    // Op field occupies the 13 MSBs of a param word; mul is the topmost bit
    localparam int OP_W      = 13;
    localparam int OP_MUL    = 12;
    localparam int OP_MULH   = 11;
    localparam int OP_MULHSU = 10;
    localparam int OP_MULHU  = 9;
    localparam int OP_DIV    = 8;
    localparam int OP_DIVU   = 7;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 5;
    localparam int OP_MULW   = 4;
    localparam int OP_DIVW   = 3;
    localparam int OP_DIVUW  = 2;
    localparam int OP_REMW   = 1;
    localparam int OP_REMUW  = 0;

    localparam logic [OP_W-1:0] MUL_MASK = OP_W'((1 << OP_MUL) | (1 << OP_MULH) |
        (1 << OP_MULHSU) | (1 << OP_MULHU) | (1 << OP_MULW));
    localparam logic [OP_W-1:0] DIV_MASK = OP_W'((1 << OP_DIV) | (1 << OP_DIVU) |
        (1 << OP_REM) | (1 << OP_REMU) | (1 << OP_DIVW) | (1 << OP_DIVUW) |
        (1 << OP_REMW) | (1 << OP_REMUW));

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - 1'b1)) == '0);
    endfunction

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return |(op & MUL_MASK);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return |(op & DIV_MASK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_issue_arb_rr_pick.sv
// ============================================================================
// muldiv_rr_pick
// Round-robin picker: first set bit of vld searching upward from ptr, with wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] vld,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((32'(ptr) + 32'(k)) % NREQ);
            if (!w_found && vld[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_issue_arb.sv
// ============================================================================
// muldiv_issue_arb
// Arbitrates NREQ issue queues onto the shared mul/div unit and sequences it.
// Define MULDIV_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_issue_arb
    import muldiv_issue_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = MUL_EXEPARAM_DW,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_vaild,
    input  logic [NREQ*DW-1:0] req_param,
    output logic [NREQ-1:0]    req_ready,
    output logic               exe_vaild,
    output logic [DW-1:0]      exe_param,
    input  logic               exe_ready,
    input  logic               wb_vaild,
    input  logic               flush,
    output logic               wb_kill,
    output logic               busy,
    output logic               wdog_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_exe_vaild;
    logic [DW-1:0]   r_exe_param;
    logic            r_wdog;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_ptr;
    logic            w_can_issue;
    logic            w_issue;
    logic [DW-1:0]   w_sel_param;
    logic [OP_W-1:0] w_sel_op;
    logic            w_wdog_set;

    // Malformed op fields never become eligible, so they stay in their queue
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_vaild[i] & op_legal(req_param[DW*i + DW - OP_W +: OP_W]);
        end
    end

    muldiv_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .vld (w_elig),
        .ptr (w_ptr),
        .gnt (w_gnt)
    );

`ifdef MULDIV_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] w_gnt_idx;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign w_ptr = r_rr_ptr;
`endif

    assign w_can_issue = (r_state == ST_IDLE) & exe_ready & ~flush & (|req_vaild);
    assign req_ready   = w_can_issue ? w_gnt : '0;
    assign w_issue     = |req_ready;

    always_comb begin
        w_sel_param = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_param = w_sel_param | req_param[DW*i +: DW];
            end
        end
    end

    assign w_sel_op = w_sel_param[DW-1 -: OP_W];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_exe_vaild <= 1'b0;
            r_exe_param <= '0;
            r_wdog      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_exe_vaild <= w_issue;
            r_wdog      <= w_wdog_set;
            if (w_issue) begin
                r_exe_param <= w_sel_param;
            end
            // Countdown keeps running through DRAIN so a lost divide still exits
            if (w_issue && is_div_op(w_sel_op)) begin
                r_cnt <= CW'(DIV_LAT);
            end else if (w_next == ST_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_next = is_mul_op(w_sel_op) ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL: begin
                if (flush || wb_vaild) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (wb_vaild) begin
                    w_next = ST_IDLE;
                end else if (flush) begin
                    w_next = ST_DRAIN;
                end else if (r_cnt == '0) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (wb_vaild || (r_cnt == '0)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != ST_IDLE);
        wb_kill    = wb_vaild & (flush | (r_state == ST_DRAIN));
        w_wdog_set = (r_state == ST_DIV) & (r_cnt == '0) & ~wb_vaild & ~flush;
    end

    assign exe_vaild = r_exe_vaild;
    assign exe_param = r_exe_param;
    assign wdog_err  = r_wdog;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_issue_arb.sv
// ============================================================================
// tb_muldiv_issue_arb
// Directed self-checking bench with an issue scoreboard for muldiv_issue_arb.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_issue_arb;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    localparam logic [31:0] OPM = 32'h8000_0000;  // mul: op field bit 12
    localparam logic [31:0] OPD = 32'h0800_0000;  // div: op field bit 8
    localparam logic [31:0] OPX = 32'h8800_0000;  // two op bits set

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [NREQ-1:0]    req_vaild = '0;
    logic [NREQ*DW-1:0] req_param = '0;
    logic [NREQ-1:0]    req_ready;
    logic               exe_vaild;
    logic [DW-1:0]      exe_param;
    logic               exe_ready = 1'b1;
    logic               wb_vaild = 1'b0;
    logic               flush = 1'b0;
    logic               wb_kill;
    logic               busy;
    logic               wdog_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];
    logic [1:0]  exp_alt [4];

    muldiv_issue_arb #(
        .NREQ    (NREQ),
        .DW      (DW),
        .DIV_LAT (66)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vaild (req_vaild),
        .req_param (req_param),
        .req_ready (req_ready),
        .exe_vaild (exe_vaild),
        .exe_param (exe_param),
        .exe_ready (exe_ready),
        .wb_vaild  (wb_vaild),
        .flush     (flush),
        .wb_kill   (wb_kill),
        .busy      (busy),
        .wdog_err  (wdog_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any issue pulse is matched against the scoreboard
    task automatic next_cyc();
        @(negedge CLK);
        #1;
        if (exe_vaild === 1'b1) begin
            if (sb.size() == 0) chk("exe_unexpected", 64'(exe_vaild), 64'd0);
            else                chk("exe_param", 64'(exe_param), 64'(sb.pop_front()));
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        req_vaild = v;
        req_param = {p1, p0};
    endtask

    task automatic grant_chk(input string tag, input logic [1:0] exp, input logic [31:0] p);
        #1;
        chk(tag, 64'(req_ready), 64'(exp));
        if (exp != 2'b00) sb.push_back(p);
    endtask

    task automatic hold(input int n, input string tag);
        repeat (n) begin
            next_cyc();
            #1;
            chk(tag, 64'(req_ready), 64'd0);
            chk("wdog_quiet", 64'(wdog_err), 64'd0);
        end
    endtask

    // Completes a multiply granted in the current cycle; optional flush with its writeback
    task automatic mul_tail(input logic kill);
        next_cyc();
        req_vaild = '0;
        #1;
        chk("mul_exe_vaild", 64'(exe_vaild), 64'd1);
        chk("mul_busy", 64'(busy), 64'd1);
        next_cyc();
        chk("mul_exe_one_cycle", 64'(exe_vaild), 64'd0);
        wb_vaild = 1'b1;
        flush    = kill;
        #1;
        chk("mul_wb_kill", 64'(wb_kill), 64'(kill));
        next_cyc();
        wb_vaild = 1'b0;
        flush    = 1'b0;
        #1;
        chk("mul_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef MULDIV_ARB_FIXED_PRIO_EN
        exp_alt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_alt = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
        // Reset state
        next_cyc();
        next_cyc();
        chk("rst_exe_vaild", 64'(exe_vaild), 64'd0);
        chk("rst_exe_param", 64'(exe_param), 64'd0);
        chk("rst_wb_kill", 64'(wb_kill), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wdog", 64'(wdog_err), 64'd0);
        RST = 1'b0;
        next_cyc();

        // Single multiply from req0
        set_req(2'b01, OPM | 32'h1, 32'h0);
        grant_chk("single_grant", 2'b01, OPM | 32'h1);
        chk("single_busy_c0", 64'(busy), 64'd0);
        mul_tail(1'b0);

        // Malformed op fields are never granted
        set_req(2'b11, 32'h0000_1234, OPX | 32'h2);
        grant_chk("illegal_nogrant", 2'b00, 32'h0);
        next_cyc();
        chk("illegal_idle", 64'(busy), 64'd0);
        set_req(2'b11, OPM | 32'h3, OPX | 32'h2);
        grant_chk("legal_vs_illegal", 2'b01, OPM | 32'h3);
        mul_tail(1'b0);

        // Both requesters continuously asking, back-to-back multiplies
        for (int g = 0; g < 4; g++) begin
            set_req(2'b11, OPM | 32'h10, OPM | 32'h20);
            grant_chk("alt_grant", exp_alt[g], (exp_alt[g] == 2'b01) ? (OPM | 32'h10) : (OPM | 32'h20));
            next_cyc();
            #1;
            chk("alt_exe_vaild", 64'(exe_vaild), 64'd1);
            chk("alt_busy_nogrant", 64'(req_ready), 64'd0);
            next_cyc();
            wb_vaild = 1'b1;
            #1;
            chk("alt_wb_nogrant", 64'(req_ready), 64'd0);
            next_cyc();
            wb_vaild = 1'b0;
        end
        req_vaild = '0;

        // Divide with writeback 64 cycles after issue
        set_req(2'b01, OPD | 32'h30, 32'h0);
        grant_chk("div_grant", 2'b01, OPD | 32'h30);
        next_cyc();
        set_req(2'b10, 32'h0, OPM | 32'h31);
        #1;
        chk("div_hold", 64'(req_ready), 64'd0);
        hold(62, "div_hold");
        next_cyc();
        wb_vaild = 1'b1;
        #1;
        chk("div_wb_kill", 64'(wb_kill), 64'd0);
        chk("div_wb_nogrant", 64'(req_ready), 64'd0);
        next_cyc();
        wb_vaild = 1'b0;
        grant_chk("div_after_wb", 2'b10, OPM | 32'h31);
        mul_tail(1'b0);

        // Divide flushed at cycle 10, writeback at 64 is drained and killed
        set_req(2'b01, OPD | 32'h40, 32'h0);
        grant_chk("drain_grant", 2'b01, OPD | 32'h40);
        next_cyc();
        set_req(2'b10, 32'h0, OPM | 32'h41);
        #1;
        chk("drain_hold", 64'(req_ready), 64'd0);
        hold(8, "drain_hold");
        next_cyc();
        flush = 1'b1;
        #1;
        chk("flush_nogrant", 64'(req_ready), 64'd0);
        next_cyc();
        flush = 1'b0;
        #1;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_no_kill", 64'(wb_kill), 64'd0);
        hold(52, "drain_hold");
        next_cyc();
        wb_vaild = 1'b1;
        #1;
        chk("drain_wb_kill", 64'(wb_kill), 64'd1);
        chk("drain_wb_nogrant", 64'(req_ready), 64'd0);
        next_cyc();
        wb_vaild = 1'b0;
        grant_chk("drain_after_wb", 2'b10, OPM | 32'h41);
        mul_tail(1'b0);

        // Flush in IDLE blocks the grant; flush with a multiply writeback kills it
        set_req(2'b01, OPM | 32'h50, 32'h0);
        flush = 1'b1;
        grant_chk("idle_flush_nogrant", 2'b00, 32'h0);
        next_cyc();
        flush = 1'b0;
        grant_chk("post_flush_grant", 2'b01, OPM | 32'h50);
        mul_tail(1'b1);

        // Divide with no writeback trips the watchdog
        set_req(2'b01, OPD | 32'h60, 32'h0);
        grant_chk("wdog_grant", 2'b01, OPD | 32'h60);
        next_cyc();
        set_req(2'b10, 32'h0, OPM | 32'h61);
        #1;
        chk("wdog_hold", 64'(req_ready), 64'd0);
        hold(66, "wdog_hold");
        next_cyc();
        chk("wdog_pulse", 64'(wdog_err), 64'd1);
        chk("wdog_idle", 64'(busy), 64'd0);
        grant_chk("wdog_next_grant", 2'b10, OPM | 32'h61);
        next_cyc();
        req_vaild = '0;
        chk("wdog_one_cycle", 64'(wdog_err), 64'd0);
        next_cyc();
        wb_vaild = 1'b1;
        next_cyc();
        wb_vaild = 1'b0;

        // Reset in the middle of a divide
        set_req(2'b01, OPD | 32'h70, 32'h0);
        grant_chk("rstdiv_grant", 2'b01, OPD | 32'h70);
        hold(19, "rstdiv_hold");
        next_cyc();
        set_req(2'b00, 32'h0, 32'h0);
        RST = 1'b1;
        #1;
        chk("midrst_exe_vaild", 64'(exe_vaild), 64'd0);
        chk("midrst_exe_param", 64'(exe_param), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wdog", 64'(wdog_err), 64'd0);
        next_cyc();
        next_cyc();
        RST = 1'b0;
        set_req(2'b11, OPM | 32'h80, OPM | 32'h81);
        grant_chk("post_rst_grant", 2'b01, OPM | 32'h80);
        mul_tail(1'b0);

        repeat (3) next_cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
